// File: rtl/tl_client_xbar_2to1.sv
// TileLink-UH 2:1 client merge crossbar: A channel arbitrated with burst lock, D routed back by source MSB.
// Define TL_XBAR_FIXED_PRIO_EN for fixed priority (port 0 over port 1) idle arbitration instead of round-robin.
module tl_client_xbar_2to1 #(
    parameter int SRC_W  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  in_0_a_valid,
    output logic                  in_0_a_ready,
    input  logic [2:0]            in_0_a_bits_opcode,
    input  logic [2:0]            in_0_a_bits_param,
    input  logic [SIZE_W-1:0]     in_0_a_bits_size,
    input  logic [SRC_W-1:0]      in_0_a_bits_source,
    input  logic [ADDR_W-1:0]     in_0_a_bits_address,
    input  logic [DATA_W/8-1:0]   in_0_a_bits_mask,
    input  logic [DATA_W-1:0]     in_0_a_bits_data,
    input  logic                  in_0_a_bits_corrupt,

    input  logic                  in_1_a_valid,
    output logic                  in_1_a_ready,
    input  logic [2:0]            in_1_a_bits_opcode,
    input  logic [2:0]            in_1_a_bits_param,
    input  logic [SIZE_W-1:0]     in_1_a_bits_size,
    input  logic [SRC_W-1:0]      in_1_a_bits_source,
    input  logic [ADDR_W-1:0]     in_1_a_bits_address,
    input  logic [DATA_W/8-1:0]   in_1_a_bits_mask,
    input  logic [DATA_W-1:0]     in_1_a_bits_data,
    input  logic                  in_1_a_bits_corrupt,

    output logic                  in_0_d_valid,
    input  logic                  in_0_d_ready,
    output logic [2:0]            in_0_d_bits_opcode,
    output logic [1:0]            in_0_d_bits_param,
    output logic [SIZE_W-1:0]     in_0_d_bits_size,
    output logic [SRC_W-1:0]      in_0_d_bits_source,
    output logic                  in_0_d_bits_sink,
    output logic                  in_0_d_bits_denied,
    output logic [DATA_W-1:0]     in_0_d_bits_data,
    output logic                  in_0_d_bits_corrupt,

    output logic                  in_1_d_valid,
    input  logic                  in_1_d_ready,
    output logic [2:0]            in_1_d_bits_opcode,
    output logic [1:0]            in_1_d_bits_param,
    output logic [SIZE_W-1:0]     in_1_d_bits_size,
    output logic [SRC_W-1:0]      in_1_d_bits_source,
    output logic                  in_1_d_bits_sink,
    output logic                  in_1_d_bits_denied,
    output logic [DATA_W-1:0]     in_1_d_bits_data,
    output logic                  in_1_d_bits_corrupt,

    output logic                  out_a_valid,
    input  logic                  out_a_ready,
    output logic [2:0]            out_a_bits_opcode,
    output logic [2:0]            out_a_bits_param,
    output logic [SIZE_W-1:0]     out_a_bits_size,
    output logic [SRC_W:0]        out_a_bits_source,
    output logic [ADDR_W-1:0]     out_a_bits_address,
    output logic [DATA_W/8-1:0]   out_a_bits_mask,
    output logic [DATA_W-1:0]     out_a_bits_data,
    output logic                  out_a_bits_corrupt,

    input  logic                  out_d_valid,
    output logic                  out_d_ready,
    input  logic [2:0]            out_d_bits_opcode,
    input  logic [1:0]            out_d_bits_param,
    input  logic [SIZE_W-1:0]     out_d_bits_size,
    input  logic [SRC_W:0]        out_d_bits_source,
    input  logic                  out_d_bits_sink,
    input  logic                  out_d_bits_denied,
    input  logic [DATA_W-1:0]     out_d_bits_data,
    input  logic                  out_d_bits_corrupt
);

    localparam int BB   = DATA_W / 8;
    localparam int LGBB = $clog2(BB);
    // Counter wide enough for the longest burst the size field can describe.
    localparam int BL_W = (1 << SIZE_W) - LGBB;
    localparam logic [SIZE_W-1:0] LGBB_S = SIZE_W'(LGBB);

    logic [BL_W-1:0] r_beatsLeft;
    logic [1:0]      r_grantQ;
    logic [1:0]      w_valids;
    logic [1:0]      w_grant;
    logic            w_idle;
    logic            w_fire;
    logic            w_hasData;
    logic [BL_W-1:0] w_beats;
    logic            w_dPort;

    assign w_valids = {in_1_a_valid, in_0_a_valid};
    assign w_idle   = (r_beatsLeft == '0);

`ifdef TL_XBAR_FIXED_PRIO_EN
    always_comb begin
        w_grant = 2'b00;
        if (!w_idle)
            w_grant = r_grantQ;
        else if (w_valids[0])
            w_grant = 2'b01;
        else if (w_valids[1])
            w_grant = 2'b10;
    end
`else
    logic r_rrLast;

    // When both ports request, the one that did not win last time goes first.
    always_comb begin
        w_grant = 2'b00;
        if (!w_idle)
            w_grant = r_grantQ;
        else if (w_valids == 2'b11)
            w_grant = r_rrLast ? 2'b01 : 2'b10;
        else
            w_grant = w_valids;
    end
`endif

    assign out_a_valid  = reset & (|(w_grant & w_valids));
    assign in_0_a_ready = reset & out_a_ready & w_grant[0];
    assign in_1_a_ready = reset & out_a_ready & w_grant[1];
    assign w_fire       = out_a_valid & out_a_ready;

    assign out_a_bits_opcode  = ({3{w_grant[0]}} & in_0_a_bits_opcode) | ({3{w_grant[1]}} & in_1_a_bits_opcode);
    assign out_a_bits_param   = ({3{w_grant[0]}} & in_0_a_bits_param)  | ({3{w_grant[1]}} & in_1_a_bits_param);
    assign out_a_bits_size    = ({SIZE_W{w_grant[0]}} & in_0_a_bits_size) | ({SIZE_W{w_grant[1]}} & in_1_a_bits_size);
    assign out_a_bits_source  = ({(SRC_W+1){w_grant[0]}} & {1'b0, in_0_a_bits_source})
                              | ({(SRC_W+1){w_grant[1]}} & {1'b1, in_1_a_bits_source});
    assign out_a_bits_address = ({ADDR_W{w_grant[0]}} & in_0_a_bits_address) | ({ADDR_W{w_grant[1]}} & in_1_a_bits_address);
    assign out_a_bits_mask    = ({BB{w_grant[0]}} & in_0_a_bits_mask) | ({BB{w_grant[1]}} & in_1_a_bits_mask);
    assign out_a_bits_data    = ({DATA_W{w_grant[0]}} & in_0_a_bits_data) | ({DATA_W{w_grant[1]}} & in_1_a_bits_data);
    assign out_a_bits_corrupt = (w_grant[0] & in_0_a_bits_corrupt) | (w_grant[1] & in_1_a_bits_corrupt);

    assign w_hasData = ~out_a_bits_opcode[2];
    assign w_beats   = (w_hasData && (out_a_bits_size > LGBB_S))
                     ? (BL_W'(1) << (out_a_bits_size - LGBB_S))
                     : BL_W'(1);

    // First beat of a burst latches the winner; later beats only count down until the lock drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_beatsLeft <= '0;
            r_grantQ    <= 2'b00;
`ifndef TL_XBAR_FIXED_PRIO_EN
            r_rrLast    <= 1'b1;
`endif
        end else if (w_idle) begin
            if (w_fire) begin
                r_beatsLeft <= w_beats - BL_W'(1);
                r_grantQ    <= w_grant;
`ifndef TL_XBAR_FIXED_PRIO_EN
                r_rrLast    <= w_grant[1];
`endif
            end else begin
                r_grantQ    <= 2'b00;
            end
        end else if (w_fire) begin
            r_beatsLeft <= r_beatsLeft - BL_W'(1);
        end
    end

    assign w_dPort      = out_d_bits_source[SRC_W];
    assign in_0_d_valid = reset & out_d_valid & ~w_dPort;
    assign in_1_d_valid = reset & out_d_valid & w_dPort;
    assign out_d_ready  = reset & (w_dPort ? in_1_d_ready : in_0_d_ready);

    assign in_0_d_bits_opcode  = out_d_bits_opcode;
    assign in_0_d_bits_param   = out_d_bits_param;
    assign in_0_d_bits_size    = out_d_bits_size;
    assign in_0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
    assign in_0_d_bits_sink    = out_d_bits_sink;
    assign in_0_d_bits_denied  = out_d_bits_denied;
    assign in_0_d_bits_data    = out_d_bits_data;
    assign in_0_d_bits_corrupt = out_d_bits_corrupt;

    assign in_1_d_bits_opcode  = out_d_bits_opcode;
    assign in_1_d_bits_param   = out_d_bits_param;
    assign in_1_d_bits_size    = out_d_bits_size;
    assign in_1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
    assign in_1_d_bits_sink    = out_d_bits_sink;
    assign in_1_d_bits_denied  = out_d_bits_denied;
    assign in_1_d_bits_data    = out_d_bits_data;
    assign in_1_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_client_xbar_2to1.sv
// Directed self-checking bench for tl_client_xbar_2to1: arbitration order, burst lock, D routing, reset mid-burst.
// Expected grants follow fixed priority when TL_XBAR_FIXED_PRIO_EN is defined.
module tb_tl_client_xbar_2to1;

    localparam int SRC_W  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 3;
    localparam int BB     = DATA_W / 8;
`ifdef TL_XBAR_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic in_0_a_valid, in_0_a_ready, in_0_a_bits_corrupt;
    logic [2:0] in_0_a_bits_opcode, in_0_a_bits_param;
    logic [SIZE_W-1:0] in_0_a_bits_size;
    logic [SRC_W-1:0] in_0_a_bits_source;
    logic [ADDR_W-1:0] in_0_a_bits_address;
    logic [BB-1:0] in_0_a_bits_mask;
    logic [DATA_W-1:0] in_0_a_bits_data;

    logic in_1_a_valid, in_1_a_ready, in_1_a_bits_corrupt;
    logic [2:0] in_1_a_bits_opcode, in_1_a_bits_param;
    logic [SIZE_W-1:0] in_1_a_bits_size;
    logic [SRC_W-1:0] in_1_a_bits_source;
    logic [ADDR_W-1:0] in_1_a_bits_address;
    logic [BB-1:0] in_1_a_bits_mask;
    logic [DATA_W-1:0] in_1_a_bits_data;

    logic in_0_d_valid, in_0_d_ready, in_0_d_bits_sink, in_0_d_bits_denied, in_0_d_bits_corrupt;
    logic [2:0] in_0_d_bits_opcode;
    logic [1:0] in_0_d_bits_param;
    logic [SIZE_W-1:0] in_0_d_bits_size;
    logic [SRC_W-1:0] in_0_d_bits_source;
    logic [DATA_W-1:0] in_0_d_bits_data;

    logic in_1_d_valid, in_1_d_ready, in_1_d_bits_sink, in_1_d_bits_denied, in_1_d_bits_corrupt;
    logic [2:0] in_1_d_bits_opcode;
    logic [1:0] in_1_d_bits_param;
    logic [SIZE_W-1:0] in_1_d_bits_size;
    logic [SRC_W-1:0] in_1_d_bits_source;
    logic [DATA_W-1:0] in_1_d_bits_data;

    logic out_a_valid, out_a_ready, out_a_bits_corrupt;
    logic [2:0] out_a_bits_opcode, out_a_bits_param;
    logic [SIZE_W-1:0] out_a_bits_size;
    logic [SRC_W:0] out_a_bits_source;
    logic [ADDR_W-1:0] out_a_bits_address;
    logic [BB-1:0] out_a_bits_mask;
    logic [DATA_W-1:0] out_a_bits_data;

    logic out_d_valid, out_d_ready, out_d_bits_sink, out_d_bits_denied, out_d_bits_corrupt;
    logic [2:0] out_d_bits_opcode;
    logic [1:0] out_d_bits_param;
    logic [SIZE_W-1:0] out_d_bits_size;
    logic [SRC_W:0] out_d_bits_source;
    logic [DATA_W-1:0] out_d_bits_data;

    int checkCount = 0;
    int errorCount = 0;

    tl_client_xbar_2to1 #(.SRC_W(SRC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
        .clock(clock), .reset(reset),
        .in_0_a_valid(in_0_a_valid), .in_0_a_ready(in_0_a_ready),
        .in_0_a_bits_opcode(in_0_a_bits_opcode), .in_0_a_bits_param(in_0_a_bits_param),
        .in_0_a_bits_size(in_0_a_bits_size), .in_0_a_bits_source(in_0_a_bits_source),
        .in_0_a_bits_address(in_0_a_bits_address), .in_0_a_bits_mask(in_0_a_bits_mask),
        .in_0_a_bits_data(in_0_a_bits_data), .in_0_a_bits_corrupt(in_0_a_bits_corrupt),
        .in_1_a_valid(in_1_a_valid), .in_1_a_ready(in_1_a_ready),
        .in_1_a_bits_opcode(in_1_a_bits_opcode), .in_1_a_bits_param(in_1_a_bits_param),
        .in_1_a_bits_size(in_1_a_bits_size), .in_1_a_bits_source(in_1_a_bits_source),
        .in_1_a_bits_address(in_1_a_bits_address), .in_1_a_bits_mask(in_1_a_bits_mask),
        .in_1_a_bits_data(in_1_a_bits_data), .in_1_a_bits_corrupt(in_1_a_bits_corrupt),
        .in_0_d_valid(in_0_d_valid), .in_0_d_ready(in_0_d_ready),
        .in_0_d_bits_opcode(in_0_d_bits_opcode), .in_0_d_bits_param(in_0_d_bits_param),
        .in_0_d_bits_size(in_0_d_bits_size), .in_0_d_bits_source(in_0_d_bits_source),
        .in_0_d_bits_sink(in_0_d_bits_sink), .in_0_d_bits_denied(in_0_d_bits_denied),
        .in_0_d_bits_data(in_0_d_bits_data), .in_0_d_bits_corrupt(in_0_d_bits_corrupt),
        .in_1_d_valid(in_1_d_valid), .in_1_d_ready(in_1_d_ready),
        .in_1_d_bits_opcode(in_1_d_bits_opcode), .in_1_d_bits_param(in_1_d_bits_param),
        .in_1_d_bits_size(in_1_d_bits_size), .in_1_d_bits_source(in_1_d_bits_source),
        .in_1_d_bits_sink(in_1_d_bits_sink), .in_1_d_bits_denied(in_1_d_bits_denied),
        .in_1_d_bits_data(in_1_d_bits_data), .in_1_d_bits_corrupt(in_1_d_bits_corrupt),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
        .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
        .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
        .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
        .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
        .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
        .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic [2:0] opcode,
                                 input logic [SIZE_W-1:0] size, input logic [SRC_W-1:0] source,
                                 input logic [ADDR_W-1:0] address, input logic [DATA_W-1:0] data);
        if (port == 0) begin
            in_0_a_valid = valid;  in_0_a_bits_opcode = opcode;  in_0_a_bits_size = size;
            in_0_a_bits_source = source;  in_0_a_bits_address = address;  in_0_a_bits_data = data;
        end else begin
            in_1_a_valid = valid;  in_1_a_bits_opcode = opcode;  in_1_a_bits_size = size;
            in_1_a_bits_source = source;  in_1_a_bits_address = address;  in_1_a_bits_data = data;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int p;
        in_0_a_bits_param = 3'd0;  in_0_a_bits_mask = 8'hFF;  in_0_a_bits_corrupt = 1'b0;
        in_1_a_bits_param = 3'd0;  in_1_a_bits_mask = 8'hFF;  in_1_a_bits_corrupt = 1'b0;
        in_0_d_ready = 1'b1;  in_1_d_ready = 1'b1;
        out_d_bits_opcode = 3'd1;  out_d_bits_param = 2'd0;  out_d_bits_size = 3'd3;
        out_d_bits_sink = 1'b0;  out_d_bits_denied = 1'b0;  out_d_bits_corrupt = 1'b0;
        out_d_bits_source = 5'h00;  out_d_bits_data = '0;

        // Handshakes must be forced low while reset is held
        applyStimulus(0, 1'b1, 3'd4, 3'd3, 4'h5, 32'h1000, 64'h0);
        applyStimulus(1, 1'b1, 3'd4, 3'd3, 4'hA, 32'h2000, 64'h0);
        out_a_ready = 1'b1;
        out_d_valid = 1'b1;
        tick(); tick();
        checkOutput("reset out_a_valid", out_a_valid, 1'b0);
        checkOutput("reset in_0_a_ready", in_0_a_ready, 1'b0);
        checkOutput("reset in_1_a_ready", in_1_a_ready, 1'b0);
        checkOutput("reset in_0_d_valid", in_0_d_valid, 1'b0);
        checkOutput("reset out_d_ready", out_d_ready, 1'b0);
        in_0_a_valid = 1'b0;  in_1_a_valid = 1'b0;  out_d_valid = 1'b0;
        reset = 1'b1;

        // Back-to-back single-beat Gets from both ports alternate
        for (int k = 0; k < 4; k++) begin
            tick();
            p = FIXED ? 0 : (k % 2);
            applyStimulus(0, 1'b1, 3'd4, 3'd3, 4'h5, 32'h1000, 64'h0);
            applyStimulus(1, 1'b1, 3'd4, 3'd3, 4'hA, 32'h2000, 64'h0);
            #2;
            checkOutput($sformatf("get%0d source", k), out_a_bits_source, (p == 1) ? 64'h1A : 64'h05);
            checkOutput($sformatf("get%0d address", k), out_a_bits_address, (p == 1) ? 64'h2000 : 64'h1000);
            checkOutput($sformatf("get%0d in_0_ready", k), in_0_a_ready, p == 0);
            checkOutput($sformatf("get%0d in_1_ready", k), in_1_a_ready, p == 1);
        end
        tick();
        in_0_a_valid = 1'b0;  in_1_a_valid = 1'b0;

        // Eight-beat PutFull on port 1 holds the grant while port 0 waits
        for (int k = 0; k < 9; k++) begin
            tick();
            applyStimulus(1, 1'b1, 3'd0, 3'd6, 4'h3, 32'h3000 + 32'(8 * k), 64'hD0 + 64'(k));
            applyStimulus(0, k >= 1, 3'd4, 3'd3, 4'h2, 32'h4000, 64'h0);
            #2;
            if (k < 8) begin
                checkOutput($sformatf("burst beat%0d source", k), out_a_bits_source, 64'h13);
                checkOutput($sformatf("burst beat%0d data", k), out_a_bits_data, 64'hD0 + 64'(k));
                checkOutput($sformatf("burst beat%0d in_0_ready", k), in_0_a_ready, 1'b0);
                checkOutput($sformatf("burst beat%0d in_1_ready", k), in_1_a_ready, 1'b1);
            end else begin
                checkOutput("after burst source", out_a_bits_source, 64'h02);
                checkOutput("after burst in_0_ready", in_0_a_ready, 1'b1);
                checkOutput("after burst in_1_ready", in_1_a_ready, 1'b0);
            end
        end
        tick();
        in_0_a_valid = 1'b0;  in_1_a_valid = 1'b0;

        // Four-beat burst with a stalling manager: lock lasts until the fourth fire
        for (int c = 0; c < 8; c++) begin
            tick();
            out_a_ready = (c % 2 == 0) || (c == 7);
            if (c < 7)
                applyStimulus(0, 1'b1, 3'd0, 3'd5, 4'h1, 32'h5000, 64'(c));
            else
                applyStimulus(0, 1'b1, 3'd4, 3'd3, 4'h1, 32'h5000, 64'h0);
            applyStimulus(1, c >= 1, 3'd4, 3'd3, 4'h9, 32'h6000, 64'h0);
            #2;
            if (c < 7) begin
                checkOutput($sformatf("stall c%0d source", c), out_a_bits_source, 64'h01);
                checkOutput($sformatf("stall c%0d out_a_valid", c), out_a_valid, 1'b1);
                checkOutput($sformatf("stall c%0d in_0_ready", c), in_0_a_ready, c % 2 == 0);
                checkOutput($sformatf("stall c%0d in_1_ready", c), in_1_a_ready, 1'b0);
            end else begin
                checkOutput("stall release source", out_a_bits_source, FIXED ? 64'h01 : 64'h19);
            end
        end
        tick();
        in_0_a_valid = 1'b0;  in_1_a_valid = 1'b0;

        // D routing by source MSB, with the MSB stripped on the client side
        out_d_valid = 1'b1;  out_d_bits_source = 5'h13;  out_d_bits_data = 64'hABCD;
        in_0_d_ready = 1'b1;  in_1_d_ready = 1'b0;
        #2;
        checkOutput("d port1 in_1_d_valid", in_1_d_valid, 1'b1);
        checkOutput("d port1 in_0_d_valid", in_0_d_valid, 1'b0);
        checkOutput("d port1 source", in_1_d_bits_source, 64'h3);
        checkOutput("d port1 data", in_1_d_bits_data, 64'hABCD);
        checkOutput("d port1 out_d_ready low", out_d_ready, 1'b0);
        in_1_d_ready = 1'b1;
        #1;
        checkOutput("d port1 out_d_ready high", out_d_ready, 1'b1);
        out_d_bits_source = 5'h05;  in_0_d_ready = 1'b0;
        #1;
        checkOutput("d port0 in_0_d_valid", in_0_d_valid, 1'b1);
        checkOutput("d port0 in_1_d_valid", in_1_d_valid, 1'b0);
        checkOutput("d port0 source", in_0_d_bits_source, 64'h5);
        checkOutput("d port0 out_d_ready", out_d_ready, 1'b0);
        out_d_valid = 1'b0;

        // Reset in the middle of an eight-beat burst drops the lock
        out_a_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(1, 1'b1, 3'd0, 3'd6, 4'h3, 32'h7000, 64'(k));
        end
        tick();
        applyStimulus(0, 1'b1, 3'd4, 3'd3, 4'h2, 32'h8000, 64'h0);
        #1;
        checkOutput("mid-burst still locked", out_a_bits_source, 64'h13);
        reset = 1'b0;
        #1;
        checkOutput("mid-burst reset out_a_valid", out_a_valid, 1'b0);
        checkOutput("mid-burst reset in_1_ready", in_1_a_ready, 1'b0);
        tick();
        reset = 1'b1;
        #2;
        checkOutput("post-reset source", out_a_bits_source, 64'h02);
        checkOutput("post-reset in_0_ready", in_0_a_ready, 1'b1);
        checkOutput("post-reset in_1_ready", in_1_a_ready, 1'b0);
        tick();
        in_0_a_valid = 1'b0;  in_1_a_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
